scratchpad_arbiter: RTL and testbench

// Shares the single scratchpad port between two requesters: HOST (the AXI-side

---
 rtl/scratchpad_arbiter_if.sv | 33 +++
 rtl/scratchpad_arbiter.sv | 164 ++++++++++++++++
 tb/tb_scratchpad_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scratchpad_arbiter_if.sv
// Request/response bundle shared by both requesters and the scratchpad port.
// The requester side uses master and the responder side uses slave.
interface scratchpad_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic              read_en;
    logic              write_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (
        output read_en,
        output write_en,
        output addr,
        output wdata,
        input  rdata,
        input  ready
    );

    modport slave (
        input  read_en,
        input  write_en,
        input  addr,
        input  wdata,
        output rdata,
        output ready
    );

endinterface

// File: rtl/scratchpad_arbiter.sv
// Shares the single scratchpad port between HOST and the array load/store
// engine (ARR). ARR bursts are bounded while HOST waits, and a watchdog
// aborts transactions that never see sc_ready.
// The scratchpad request and the requester responses are forwarded
// combinationally from the granted requester; only the arbitration state,
// the burst counter, the watchdog and the sticky error are registered.
module scratchpad_arbiter #(
    parameter int unsigned BURST_MAX = 4,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    scratchpad_arbiter_if.slave         host_if,
    scratchpad_arbiter_if.slave         arr_if,
    scratchpad_arbiter_if.master        sc_if,
    output logic                        timeout_err_o
);

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STREAK_W = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
    localparam int unsigned WD_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(BURST_MAX);
    localparam logic [WD_W-1:0]     WD_LAST    = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_HOST = 2'd1,
        GNT_ARR  = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_HOST = 1'b0,
        GRANT_ARR  = 1'b1
    } grant_e;

    state_e                state_q,       state_d;
    grant_e                last_grant_q,  last_grant_d;
    logic [STREAK_W-1:0]   arr_streak_q,  arr_streak_d;
    logic [WD_W-1:0]       wd_cnt_q,      wd_cnt_d;
    logic                  timeout_err_q, timeout_err_d;

    logic                  req_host;
    logic                  req_arr;
    logic                  arr_turn;

    logic                  sel_req;
    logic                  sel_rd;
    logic                  sel_wr;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_wdata;

    assign req_host = host_if.read_en | host_if.write_en;
    assign req_arr  = arr_if.read_en  | arr_if.write_en;

    // ARR keeps priority on contention until its streak reaches BURST_MAX.
    assign arr_turn = (arr_streak_q < STREAK_MAX) || (last_grant_q == GRANT_HOST);

    assign timeout_err_o = timeout_err_q;

    // Select the request bundle of the requester that currently owns the port.
    always_comb begin
        if (state_q == GNT_HOST) begin
            sel_req   = req_host;
            sel_rd    = host_if.read_en;
            sel_wr    = host_if.write_en;
            sel_addr  = host_if.addr;
            sel_wdata = host_if.wdata;
        end else begin
            sel_req   = req_arr;
            sel_rd    = arr_if.read_en;
            sel_wr    = arr_if.write_en;
            sel_addr  = arr_if.addr;
            sel_wdata = arr_if.wdata;
        end
    end

    // Arbitration state register, burst counter, watchdog and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            last_grant_q  <= GRANT_ARR;
            arr_streak_q  <= '0;
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            arr_streak_q  <= arr_streak_d;
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state decision and combinational forwarding of the granted request.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        arr_streak_d  = arr_streak_q;
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = timeout_err_q;

        sc_if.read_en  = 1'b0;
        sc_if.write_en = 1'b0;
        sc_if.addr     = '0;
        sc_if.wdata    = '0;
        host_if.ready  = 1'b0;
        host_if.rdata  = '0;
        arr_if.ready   = 1'b0;
        arr_if.rdata   = '0;

        unique case (state_q)
            IDLE: begin
                wd_cnt_d = '0;
                if (req_host && (!req_arr || !arr_turn)) begin
                    state_d      = GNT_HOST;
                    last_grant_d = GRANT_HOST;
                    arr_streak_d = '0;
                end else if (req_arr) begin
                    state_d      = GNT_ARR;
                    last_grant_d = GRANT_ARR;
                    // The streak only counts grants that made HOST wait.
                    arr_streak_d = req_host ? (arr_streak_q + STREAK_W'(1)) : '0;
                end
            end

            GNT_HOST, GNT_ARR: begin
                if (!sel_req) begin
                    // Requester withdrew: drop the enables, no completion.
                    state_d = IDLE;
                end else begin
                    // Write wins when both enables are raised.
                    sc_if.write_en = sel_wr;
                    sc_if.read_en  = sel_rd & ~sel_wr;
                    sc_if.addr     = sel_addr;
                    sc_if.wdata    = sel_wdata;

                    if (sc_if.ready) begin
                        state_d = IDLE;
                        if (state_q == GNT_HOST) begin
                            host_if.ready = 1'b1;
                            host_if.rdata = sel_wr ? '0 : sc_if.rdata;
                        end else begin
                            arr_if.ready = 1'b1;
                            arr_if.rdata = sel_wr ? '0 : sc_if.rdata;
                        end
                    end else if (wd_cnt_q == WD_LAST) begin
                        // Hung transaction: abort silently and flag it.
                        timeout_err_d = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        wd_cnt_d = wd_cnt_q + WD_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_scratchpad_arbiter.sv
// Directed bench for scratchpad_arbiter: a per-cycle vector table for the
// single-transaction behaviour plus hand-written multi-cycle sequences for
// burst fairness, watchdog abort and reset during a grant.
module tb_scratchpad_arbiter;

    logic clk;
    logic rst;
    logic timeout_err;

    int n_checks;
    int n_fail;

    scratchpad_arbiter_if host_bus ();
    scratchpad_arbiter_if arr_bus ();
    scratchpad_arbiter_if sc_bus ();

    scratchpad_arbiter #(
        .BURST_MAX (4),
        .TIMEOUT   (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .host_if       (host_bus),
        .arr_if        (arr_bus),
        .sc_if         (sc_bus),
        .timeout_err_o (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        h_rd;
        logic        h_wr;
        logic [31:0] h_addr;
        logic [31:0] h_wdata;
        logic        a_rd;
        logic        a_wr;
        logic [31:0] a_addr;
        logic [31:0] a_wdata;
        logic        sc_rdy;
        logic [31:0] sc_dout;
        logic        e_rd;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_din;
        logic        e_hrdy;
        logic [31:0] e_hrdata;
        logic        e_ardy;
        logic [31:0] e_ardata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(
        input logic h_rd, input logic h_wr, input logic [31:0] h_addr, input logic [31:0] h_wdata,
        input logic a_rd, input logic a_wr, input logic [31:0] a_addr, input logic [31:0] a_wdata,
        input logic sc_rdy, input logic [31:0] sc_dout,
        input logic e_rd, input logic e_wr, input logic [31:0] e_addr, input logic [31:0] e_din,
        input logic e_hrdy, input logic [31:0] e_hrdata, input logic e_ardy, input logic [31:0] e_ardata
    );
        vec_t v;
        v.h_rd = h_rd;     v.h_wr = h_wr;     v.h_addr = h_addr;     v.h_wdata = h_wdata;
        v.a_rd = a_rd;     v.a_wr = a_wr;     v.a_addr = a_addr;     v.a_wdata = a_wdata;
        v.sc_rdy = sc_rdy; v.sc_dout = sc_dout;
        v.e_rd = e_rd;     v.e_wr = e_wr;     v.e_addr = e_addr;     v.e_din = e_din;
        v.e_hrdy = e_hrdy; v.e_hrdata = e_hrdata;
        v.e_ardy = e_ardy; v.e_ardata = e_ardata;
        vecs.push_back(v);
    endtask

    task automatic clear_inputs();
        host_bus.read_en  = 1'b0;
        host_bus.write_en = 1'b0;
        host_bus.addr     = '0;
        host_bus.wdata    = '0;
        arr_bus.read_en   = 1'b0;
        arr_bus.write_en  = 1'b0;
        arr_bus.addr      = '0;
        arr_bus.wdata     = '0;
        sc_bus.ready      = 1'b0;
        sc_bus.rdata      = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] order [10];
        logic [1:0] exp_order [10];
        int         n_grants;
        int         age;
        int         cyc;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        clear_inputs();

        // hr hw haddr hwdata | ar aw aaddr awdata | rdy dout | e_rd e_wr e_addr e_din | hrdy hrdata | ardy ardata
        // HOST read 0x10, completion two cycles after the grant
        add(1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0,        1'b0,1'b0,32'h0,32'h0,  1'b0,32'h0,        1'b0,32'h0);
        add(1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0,        1'b1,1'b0,32'h10,32'h0, 1'b0,32'h0,        1'b0,32'h0);
        add(1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0,        1'b1,1'b0,32'h10,32'h0, 1'b0,32'h0,        1'b0,32'h0);
        add(1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,32'hDEADBEEF, 1'b1,1'b0,32'h10,32'h0, 1'b1,32'hDEADBEEF, 1'b0,32'h0);
        add(1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0,        1'b0,1'b0,32'h0,32'h0,  1'b0,32'h0,        1'b0,32'h0);
        // sc_ready while idle is ignored
        add(1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0,32'h0,32'h0, 1'b1,32'h1234,     1'b0,1'b0,32'h0,32'h0,  1'b0,32'h0,        1'b0,32'h0);
        // HOST read+write: write wins, rdata 0 on completion
        add(1'b1,1'b1,32'h20,32'h5, 1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0,        1'b0,1'b0,32'h0,32'h0,  1'b0,32'h0,        1'b0,32'h0);
        add(1'b1,1'b1,32'h20,32'h5, 1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0,        1'b0,1'b1,32'h20,32'h5, 1'b0,32'h0,        1'b0,32'h0);
        add(1'b1,1'b1,32'h20,32'h5, 1'b0,1'b0,32'h0,32'h0, 1'b1,32'hFFFFFFFF, 1'b0,1'b1,32'h20,32'h5, 1'b1,32'h0,        1'b0,32'h0);
        add(1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0,        1'b0,1'b0,32'h0,32'h0,  1'b0,32'h0,        1'b0,32'h0);
        // ARR read with single-cycle completion
        add(1'b0,1'b0,32'h0,32'h0,  1'b1,1'b0,32'h40,32'h0, 1'b0,32'h0,        1'b0,1'b0,32'h0,32'h0,  1'b0,32'h0,        1'b0,32'h0);
        add(1'b0,1'b0,32'h0,32'h0,  1'b1,1'b0,32'h40,32'h0, 1'b1,32'hA5A5A5A5, 1'b1,1'b0,32'h40,32'h0, 1'b0,32'h0,        1'b1,32'hA5A5A5A5);
        add(1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0,        1'b0,1'b0,32'h0,32'h0,  1'b0,32'h0,        1'b0,32'h0);
        // ARR write withdrawn before completion: no ready even with sc_ready
        add(1'b0,1'b0,32'h0,32'h0,  1'b0,1'b1,32'h44,32'h7, 1'b0,32'h0,        1'b0,1'b0,32'h0,32'h0,  1'b0,32'h0,        1'b0,32'h0);
        add(1'b0,1'b0,32'h0,32'h0,  1'b0,1'b1,32'h44,32'h7, 1'b0,32'h0,        1'b0,1'b1,32'h44,32'h7, 1'b0,32'h0,        1'b0,32'h0);
        add(1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0,32'h0,32'h0, 1'b1,32'h99,       1'b0,1'b0,32'h0,32'h0,  1'b0,32'h0,        1'b0,32'h0);
        add(1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0,32'h0,32'h0, 1'b1,32'h99,       1'b0,1'b0,32'h0,32'h0,  1'b0,32'h0,        1'b0,32'h0);
        // Simultaneous requests: ARR first
        add(1'b1,1'b0,32'h60,32'h0, 1'b1,1'b0,32'h64,32'h0, 1'b0,32'h0,        1'b0,1'b0,32'h0,32'h0,  1'b0,32'h0,        1'b0,32'h0);
        add(1'b1,1'b0,32'h60,32'h0, 1'b1,1'b0,32'h64,32'h0, 1'b1,32'h11,       1'b1,1'b0,32'h64,32'h0, 1'b0,32'h0,        1'b1,32'h11);
        add(1'b1,1'b0,32'h60,32'h0, 1'b1,1'b0,32'h64,32'h0, 1'b0,32'h0,        1'b0,1'b0,32'h0,32'h0,  1'b0,32'h0,        1'b0,32'h0);
        add(1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0,        1'b0,1'b0,32'h0,32'h0,  1'b0,32'h0,        1'b0,32'h0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst.sc_read_en", sc_bus.read_en, 1'b0);
        chk1("rst.sc_write_en", sc_bus.write_en, 1'b0);
        chk1("rst.host_ready", host_bus.ready, 1'b0);
        chk1("rst.arr_ready", arr_bus.ready, 1'b0);
        chk1("rst.timeout_err", timeout_err, 1'b0);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            host_bus.read_en  = vecs[i].h_rd;
            host_bus.write_en = vecs[i].h_wr;
            host_bus.addr     = vecs[i].h_addr;
            host_bus.wdata    = vecs[i].h_wdata;
            arr_bus.read_en   = vecs[i].a_rd;
            arr_bus.write_en  = vecs[i].a_wr;
            arr_bus.addr      = vecs[i].a_addr;
            arr_bus.wdata     = vecs[i].a_wdata;
            sc_bus.ready      = vecs[i].sc_rdy;
            sc_bus.rdata      = vecs[i].sc_dout;
            @(negedge clk);
            chk1 ($sformatf("v%0d.sc_read_en", i),  sc_bus.read_en,   vecs[i].e_rd);
            chk1 ($sformatf("v%0d.sc_write_en", i), sc_bus.write_en,  vecs[i].e_wr);
            chk32($sformatf("v%0d.sc_addr", i),     sc_bus.addr,      vecs[i].e_addr);
            chk32($sformatf("v%0d.sc_data_in", i),  sc_bus.wdata,     vecs[i].e_din);
            chk1 ($sformatf("v%0d.host_ready", i),  host_bus.ready,   vecs[i].e_hrdy);
            chk32($sformatf("v%0d.host_rdata", i),  host_bus.rdata,   vecs[i].e_hrdata);
            chk1 ($sformatf("v%0d.arr_ready", i),   arr_bus.ready,    vecs[i].e_ardy);
            chk32($sformatf("v%0d.arr_rdata", i),   arr_bus.rdata,    vecs[i].e_ardata);
        end

        // Burst fairness: both request continuously, completion one cycle after grant
        do_reset();
        host_bus.read_en = 1'b1;
        host_bus.addr    = 32'h100;
        arr_bus.read_en  = 1'b1;
        arr_bus.addr     = 32'h200;
        exp_order = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
        for (int i = 0; i < 10; i++) order[i] = 2'd3;
        n_grants = 0;
        age      = 0;
        cyc      = 0;
        while (n_grants < 10 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (sc_bus.read_en) age++;
            else                age = 0;
            sc_bus.ready = sc_bus.read_en && (age == 2);
            sc_bus.rdata = 32'hC0DE;
            @(negedge clk);
            if (host_bus.ready) begin
                order[n_grants] = 2'd0;
                n_grants++;
            end else if (arr_bus.ready) begin
                order[n_grants] = 2'd1;
                n_grants++;
            end
        end
        chk32("burst.grant_count", 32'(n_grants), 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk32($sformatf("burst.grant%0d(0=HOST,1=ARR)", i), 32'(order[i]), 32'(exp_order[i]));
        end

        // Watchdog: ARR write never completes
        do_reset();
        arr_bus.write_en = 1'b1;
        arr_bus.addr     = 32'h300;
        arr_bus.wdata    = 32'hABC;
        @(negedge clk);
        chk1("wd.idle_sc_write_en", sc_bus.write_en, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk1($sformatf("wd.grant%0d.sc_write_en", k), sc_bus.write_en, 1'b1);
            chk1($sformatf("wd.grant%0d.arr_ready", k), arr_bus.ready, 1'b0);
            chk1($sformatf("wd.grant%0d.timeout_err", k), timeout_err, 1'b0);
        end
        @(posedge clk);
        #1;
        arr_bus.write_en = 1'b0;
        @(negedge clk);
        chk1("wd.after.timeout_err", timeout_err, 1'b1);
        chk1("wd.after.sc_write_en", sc_bus.write_en, 1'b0);
        chk1("wd.after.arr_ready", arr_bus.ready, 1'b0);

        // HOST served normally after the abort; error stays sticky
        @(posedge clk);
        #1;
        host_bus.read_en = 1'b1;
        host_bus.addr    = 32'h50;
        @(posedge clk);
        #1;
        sc_bus.ready = 1'b1;
        sc_bus.rdata = 32'h77;
        @(negedge clk);
        chk1 ("wd.host.sc_read_en", sc_bus.read_en, 1'b1);
        chk32("wd.host.sc_addr", sc_bus.addr, 32'h50);
        chk1 ("wd.host.host_ready", host_bus.ready, 1'b1);
        chk32("wd.host.host_rdata", host_bus.rdata, 32'h77);
        chk1 ("wd.host.timeout_err", timeout_err, 1'b1);

        // Reset asserted while ARR is granted
        @(posedge clk);
        #1;
        host_bus.read_en = 1'b0;
        sc_bus.ready     = 1'b0;
        arr_bus.read_en  = 1'b1;
        arr_bus.addr     = 32'h400;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1("rstg.granted.sc_read_en", sc_bus.read_en, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sc_bus.ready = 1'b1;
        @(negedge clk);
        chk1 ("rstg.sc_read_en", sc_bus.read_en, 1'b0);
        chk1 ("rstg.sc_write_en", sc_bus.write_en, 1'b0);
        chk32("rstg.sc_addr", sc_bus.addr, 32'h0);
        chk1 ("rstg.arr_ready", arr_bus.ready, 1'b0);
        chk1 ("rstg.timeout_err", timeout_err, 1'b0);
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
